// File: rtl/led_pkg.sv
// led_pkg: shared types and constants for the LED frame packer
package led_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_e;
    typedef enum logic {ORDER_GRB = 1'b0, ORDER_RGB = 1'b1} color_order_e;
    localparam int GAIN_W = 8;
endpackage

// File: rtl/led_color_scale.sv
// led_color_scale: expands a mean value to OUT_W bits and applies brightness gain
module led_color_scale
    import led_pkg::*;
#(
    parameter int MEAN_W = 4,
    parameter int OUT_W  = 8
) (
    input  logic [MEAN_W-1:0] mean,
    input  logic [GAIN_W-1:0] gain,
    output logic [OUT_W-1:0]  scaled
);
    logic [OUT_W-1:0] expanded;
    logic [OUT_W+8:0] product;
    // bit replication MSB-first; degenerates to taking the MSBs when MEAN_W >= OUT_W
    for (genvar i = 0; i < OUT_W; i++) begin : g_exp
        assign expanded[OUT_W-1-i] = mean[MEAN_W-1-(i%MEAN_W)];
    end
    // gain+1 makes 255 an exact identity after the >>8
    assign product = (OUT_W+9)'(expanded) * ((OUT_W+9)'(gain) + (OUT_W+9)'(1));
    assign scaled  = product[OUT_W+7:8];
endmodule

// File: rtl/led_frame_packer.sv
// led_frame_packer: snapshots zone means and queues one scaled LED frame into the transmit FIFO
module led_frame_packer
    import led_pkg::*;
#(
    parameter int NUM_ZONES   = 8,
    parameter int MEAN_W      = 4,
    parameter int OUT_W       = 8,
    parameter int COLOR_ORDER = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               start,
    input  logic                               rev,
    input  logic [GAIN_W-1:0]                  gain,
    input  logic [NUM_ZONES-1:0][MEAN_W-1:0]   mean_r,
    input  logic [NUM_ZONES-1:0][MEAN_W-1:0]   mean_g,
    input  logic [NUM_ZONES-1:0][MEAN_W-1:0]   mean_b,
    input  logic                               fifo_full,
    output logic                               we,
    output logic [OUT_W-1:0]                   fifo_data,
    output logic                               send_start,
    output logic                               busy,
    output logic                               drop
);
    localparam int ZW = NUM_ZONES > 1 ? $clog2(NUM_ZONES) : 1;
    localparam logic [ZW-1:0] LAST_ZONE = ZW'(NUM_ZONES - 1);
    localparam logic RGB = color_order_e'(COLOR_ORDER) == ORDER_RGB;

    state_e                             state;
    logic [ZW-1:0]                      zone;
    logic [1:0]                         col;
    logic [NUM_ZONES-1:0][MEAN_W-1:0]   snap_r, snap_g, snap_b;
    logic                               snap_rev;
    logic [GAIN_W-1:0]                  snap_gain;
    logic [ZW-1:0]                      zsel;
    logic [MEAN_W-1:0]                  sel;

    // frame FSM: snapshot on accept, walk zone/colour on each accepted write, pulse done
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            zone      <= '0;
            col       <= '0;
            snap_r    <= '0;
            snap_g    <= '0;
            snap_b    <= '0;
            snap_rev  <= 1'b0;
            snap_gain <= '0;
            drop      <= 1'b0;
        end else begin
            drop <= start && en && state != IDLE;
            case (state)
                IDLE: if (start && en) begin
                    snap_r    <= mean_r;
                    snap_g    <= mean_g;
                    snap_b    <= mean_b;
                    snap_rev  <= rev;
                    snap_gain <= gain;
                    zone      <= '0;
                    col       <= '0;
                    state     <= WRITE;
                end
                WRITE: if (!fifo_full) begin
                    if (col == 2'd2) begin
                        col  <= 2'd0;
                        zone <= zone + 1'b1;
                        if (zone == LAST_ZONE) state <= DONE;
                    end else begin
                        col <= col + 2'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // zone scan direction and colour-order mux from the snapshot
    always_comb begin
        zsel = snap_rev ? LAST_ZONE - zone : zone;
        sel  = col == 2'd2 ? snap_b[zsel] : ((col == 2'd0) ^ RGB) ? snap_g[zsel] : snap_r[zsel];
    end

    assign busy       = state != IDLE;
    assign we         = state == WRITE && !fifo_full;
    assign send_start = state == DONE;

    led_color_scale #(.MEAN_W(MEAN_W), .OUT_W(OUT_W)) u_scale (
        .mean   (sel),
        .gain   (snap_gain),
        .scaled (fifo_data)
    );
endmodule

// File: tb/tb_led_frame_packer.sv
// tb_led_frame_packer: directed self-checking bench for both colour orders
module tb_led_frame_packer;
    logic clk = 1'b0, rst, en, start, rev, fifo_full;
    logic [7:0] gain;
    logic [7:0][3:0] mean_r, mean_g, mean_b;
    logic we0, we1, ss0, ss1, busy0, busy1, drop0, drop1;
    logic [7:0] data0, data1;
    logic [3:0] mr[8], mg[8], mb[8];
    logic [7:0] got0[24], got1[24];
    int vec = 0, miscomp = 0;

    always #5 clk = ~clk;

    led_frame_packer #(.NUM_ZONES(8), .MEAN_W(4), .OUT_W(8), .COLOR_ORDER(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .start(start), .rev(rev), .gain(gain),
        .mean_r(mean_r), .mean_g(mean_g), .mean_b(mean_b), .fifo_full(fifo_full),
        .we(we0), .fifo_data(data0), .send_start(ss0), .busy(busy0), .drop(drop0)
    );
    led_frame_packer #(.NUM_ZONES(8), .MEAN_W(4), .OUT_W(8), .COLOR_ORDER(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .start(start), .rev(rev), .gain(gain),
        .mean_r(mean_r), .mean_g(mean_g), .mean_b(mean_b), .fifo_full(fifo_full),
        .we(we1), .fifo_data(data1), .send_start(ss1), .busy(busy1), .drop(drop1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vec++;
        assert (obs === expv) else begin
            miscomp++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_means();
        for (int i = 0; i < 8; i++) begin
            mean_r[i] = mr[i];
            mean_g[i] = mg[i];
            mean_b[i] = mb[i];
        end
    endtask

    function automatic logic [7:0] exp_word(input int order, input logic rv, input logic [7:0] gn, input int k);
        int z, c, m;
        z = rv ? 7 - k / 3 : k / 3;
        c = k % 3;
        if (c == 2) m = int'(mb[z]);
        else if (order == 0) m = c == 0 ? int'(mg[z]) : int'(mr[z]);
        else m = c == 0 ? int'(mr[z]) : int'(mg[z]);
        return 8'((m * 17 * (int'(gn) + 1)) >> 8);
    endfunction

    task automatic frame(input logic rv, input logic [7:0] gn, input int s_lo, input int s_hi, input logic en_off);
        int k, cyc, stalls;
        stalls = (s_lo > 0 && s_hi >= s_lo) ? s_hi - s_lo + 1 : 0;
        rev = rv; gain = gn; en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; rev = ~rv; gain = ~gn;
        mean_r = ~mean_r; mean_g = ~mean_g; mean_b = ~mean_b;
        if (en_off) en = 1'b0;
        k = 0;
        cyc = 1;
        while (k < 24 && cyc < 100) begin
            fifo_full = cyc >= s_lo && cyc <= s_hi;
            #1;
            chk("busy", busy0, 1);
            if (fifo_full) begin
                chk("stall_we0", we0, 0);
                chk("stall_we1", we1, 0);
                chk("stall_data0", data0, exp_word(0, rv, gn, k));
            end else begin
                chk("we0", we0, 1);
                chk("we1", we1, 1);
                chk("data0", data0, exp_word(0, rv, gn, k));
                chk("data1", data1, exp_word(1, rv, gn, k));
                got0[k] = data0;
                got1[k] = data1;
                k++;
            end
            tick();
            cyc++;
        end
        fifo_full = 1'b0;
        #1;
        chk("frame_words", k, 24);
        chk("done_cycle", cyc, 25 + stalls);
        chk("send_start0", ss0, 1);
        chk("send_start1", ss1, 1);
        chk("done_we", we0, 0);
        tick();
        chk("after_send", ss0, 0);
        chk("after_busy", busy0, 0);
        en = 1'b1;
        drive_means();
    endtask

    initial begin
        int nw, nd, ns;
        rst = 1'b1; en = 1'b0; start = 1'b0; rev = 1'b0; gain = 8'hFF; fifo_full = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mr[i] = 4'(i + 1);
            mg[i] = 4'(8 - i);
            mb[i] = 4'hF;
        end
        drive_means();
        tick(); tick();
        chk("rst_we", we0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_send", ss0, 0);
        chk("rst_drop", drop0, 0);
        chk("rst_data", data0, 8'h00);
        rst = 1'b0;
        tick();

        frame(1'b0, 8'hFF, 0, 0, 1'b0);
        chk("fwd_w0", got0[0], 8'h88);
        chk("fwd_w1", got0[1], 8'h11);
        chk("fwd_w2", got0[2], 8'hFF);
        chk("fwd_rgb_w0", got1[0], 8'h11);

        frame(1'b1, 8'hFF, 0, 0, 1'b0);
        chk("rev_w0", got1[0], 8'h88);
        chk("rev_w1", got1[1], 8'h11);
        chk("rev_w2", got1[2], 8'hFF);
        chk("rev_w21", got1[21], 8'h11);
        chk("rev_w22", got1[22], 8'h88);
        chk("rev_w23", got1[23], 8'hFF);

        for (int i = 0; i < 8; i++) begin
            mr[i] = 4'hF;
            mg[i] = 4'hF;
        end
        drive_means();
        frame(1'b0, 8'd127, 0, 0, 1'b1);
        chk("g127_w0", got0[0], 8'h7F);
        chk("g127_w23", got0[23], 8'h7F);
        frame(1'b0, 8'd0, 0, 0, 1'b0);
        chk("g0_w5", got0[5], 8'h00);

        for (int i = 0; i < 8; i++) begin
            mr[i] = 4'(i + 1);
            mg[i] = 4'(8 - i);
        end
        drive_means();
        frame(1'b0, 8'hFF, 3, 7, 1'b0);

        rev = 1'b0; gain = 8'hFF; en = 1'b1; start = 1'b1;
        nw = 0; nd = 0; ns = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            start = 1'b0;
            if (we0) begin
                chk("drop_data", data0, exp_word(0, 1'b0, 8'hFF, nw));
                nw++;
            end
            if (drop0) begin
                nd++;
                chk("drop_cycle", c, nd == 1 ? 6 : 26);
            end
            if (ss0) begin
                ns++;
                chk("drop_ss_cycle", c, 25);
            end
            start = c == 5 || c == 25;
        end
        chk("drop_writes", nw, 24);
        chk("drop_count", nd, 2);
        chk("drop_sends", ns, 1);

        en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("en0_busy", busy0, 0);
        tick();
        chk("en0_drop", drop0, 0);
        chk("en0_we", we0, 0);
        en = 1'b1;

        start = 1'b1;
        nw = 0;
        for (int c = 1; c < 40 && nw < 10; c++) begin
            tick();
            start = 1'b0;
            if (we0) nw++;
        end
        chk("pre_rst_writes", nw, 10);
        rst = 1'b1;
        tick();
        chk("mid_rst_we", we0, 0);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_send", ss0, 0);
        chk("mid_rst_drop", drop0, 0);
        chk("mid_rst_data", data0, 8'h00);
        rst = 1'b0;
        ns = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (ss0 || we0) ns++;
        end
        chk("post_rst_quiet", ns, 0);
        frame(1'b0, 8'hFF, 0, 0, 1'b0);
        chk("post_rst_w0", got0[0], 8'h88);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
        $finish;
    end
endmodule
